f1_light_seq: RTL and testbench

Parametrised F1 start-light sequencer, next generation of the fixed 8-light fill FSM.
- On a trigger it fills NUM_LIGHTS lights one per enable tick.
- It then holds all lights on for a programmable number of ticks.
- It then extinguishes all lights and pulses lights_out, which starts the downstream reaction timer.
- Supports abort; ignores re-trigger while a sequence is running. Sits between the tick/clock-divider logic and the light driver and reaction-timer blocks.

---
 rtl/f1_pkg.sv | 21 ++
 rtl/f1_hold_timer.sv | 28 ++
 rtl/f1_light_seq.sv | 118 +++++++++++
 tb/tb_f1_light_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// Shared types and helpers for the F1 start-light sequencer.
// Holds the sequencer state encoding and the thermometer-pattern helper.
package f1_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam int MAX_LIGHTS = 32;

    // Lowest cnt bits set; cnt >= 32 yields all ones.
    function automatic logic [MAX_LIGHTS-1:0] therm(input logic [5:0] cnt);
        logic [MAX_LIGHTS:0] full;
        full = (33'd1 << cnt) - 33'd1;
        return full[MAX_LIGHTS-1:0];
    endfunction

endpackage

// File: rtl/f1_hold_timer.sv
// Hold-phase down-counter: loads the latched delay, counts en ticks to zero.
// done is decoded from the registered count only.
module f1_hold_timer #(
    parameter int DELAY_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DELAY_W-1:0] load_value,
    input  logic               en,
    output logic               done
);

    logic [DELAY_W-1:0] r_timer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (load) begin
            r_timer <= load_value;
        end else if (en && (r_timer != '0)) begin
            r_timer <= r_timer - DELAY_W'(1);
        end
    end

    assign done = (r_timer == '0);

endmodule

// File: rtl/f1_light_seq.sv
// F1 start-light sequencer: fill lights one per tick, hold, then extinguish
// with a one-clock lights_out pulse. Outputs decode registered state only.
module f1_light_seq
    import f1_pkg::*;
#(
    parameter int NUM_LIGHTS = 8,
    parameter int DELAY_W    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  trigger,
    input  logic                  abort,
    input  logic [DELAY_W-1:0]    delay_in,
    output logic [NUM_LIGHTS-1:0] data_out,
    output logic                  busy,
    output logic                  lights_out
);

    localparam int              CNT_W = $clog2(NUM_LIGHTS + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_LIGHTS - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(NUM_LIGHTS);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [DELAY_W-1:0] r_delay;
    logic [DELAY_W-1:0] w_delay_next;
    logic               w_load;
    logic               w_tick_hold;
    logic               w_timer_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_delay <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_delay <= w_delay_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_delay_next = r_delay;
        w_load       = 1'b0;
        w_tick_hold  = 1'b0;
        if (abort && (r_state != IDLE)) begin
            w_state_next = IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (trigger) begin
                        w_delay_next = delay_in;
                        w_count_next = '0;
                        w_state_next = FILL;
                    end
                end
                FILL: begin
                    if (en) begin
                        if (r_count == LAST) begin
                            w_count_next = FULL;
                            w_load       = 1'b1;
                            w_state_next = HOLD;
                        end else begin
                            w_count_next = r_count + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (en) begin
                        if (w_timer_done) begin
                            w_state_next = OUT;
                        end else begin
                            w_tick_hold = 1'b1;
                        end
                    end
                end
                OUT: begin
                    // Triggers arriving now are dropped; they must be seen again in IDLE.
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    f1_hold_timer #(
        .DELAY_W (DELAY_W)
    ) u_hold_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (w_load),
        .load_value (r_delay),
        .en         (w_tick_hold),
        .done       (w_timer_done)
    );

    always_comb begin
        data_out = '0;
        case (r_state)
            FILL:    data_out = NUM_LIGHTS'(therm(6'(r_count)));
            HOLD:    data_out = '1;
            default: data_out = '0;
        endcase
    end

    assign busy       = (r_state == FILL) || (r_state == HOLD);
    assign lights_out = (r_state == OUT);

endmodule

// File: tb/tb_f1_light_seq.sv
// Directed bench for f1_light_seq: 8-light instance plus 1- and 32-light
// instances with a 4-bit delay, all sharing the same stimulus.
module tb_f1_light_seq;

    logic        clk;
    logic        rst;
    logic        en;
    logic        trigger;
    logic        abort;
    logic [6:0]  delay;

    logic [7:0]  d8;
    logic        busy8;
    logic        lo8;
    logic [0:0]  d1;
    logic        busy1;
    logic        lo1;
    logic [31:0] d32;
    logic        busy32;
    logic        lo32;

    int n_cmp = 0;
    int n_err = 0;

    f1_light_seq #(.NUM_LIGHTS(8), .DELAY_W(7)) dut8 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .abort(abort),
        .delay_in(delay), .data_out(d8), .busy(busy8), .lights_out(lo8)
    );

    f1_light_seq #(.NUM_LIGHTS(1), .DELAY_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .abort(abort),
        .delay_in(delay[3:0]), .data_out(d1), .busy(busy1), .lights_out(lo1)
    );

    f1_light_seq #(.NUM_LIGHTS(32), .DELAY_W(4)) dut32 (
        .clk(clk), .rst(rst), .en(en), .trigger(trigger), .abort(abort),
        .delay_in(delay[3:0]), .data_out(d32), .busy(busy32), .lights_out(lo32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] exp;
        int hold_cnt;
        int h1, h32, f1c, f32c, p1, p32;

        rst = 1'b1; en = 1'b1; trigger = 1'b0; abort = 1'b0; delay = 7'd3;
        #2 rst = 1'b0;
        #1;
        check("reset_data", {24'd0, d8}, 32'h0);
        check("reset_busy", {31'd0, busy8}, 32'h0);
        check("reset_lo",   {31'd0, lo8}, 32'h0);
        step();
        rst = 1'b1;
        step();

        // 1: basic fill / hold 4 / pulse
        delay = 7'd3; en = 1'b1; trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("t1_first", {24'd0, d8}, 32'h0);
        check("t1_busy",  {31'd0, busy8}, 32'h1);
        for (int i = 1; i < 8; i++) begin
            step();
            exp = (32'd1 << i) - 32'd1;
            check($sformatf("t1_fill%0d", i), {24'd0, d8}, exp);
        end
        for (int h = 0; h < 4; h++) begin
            step();
            check($sformatf("t1_hold%0d", h), {23'd0, lo8, d8}, 32'hFF);
        end
        step();
        check("t1_out", {22'd0, busy8, lo8, d8}, 32'h100);
        step();
        check("t1_idle", {22'd0, busy8, lo8, d8}, 32'h0);
        $display("test1 basic sequence done");

        // 2: zero delay, en every 2nd clk
        delay = 7'd0; en = 1'b0; trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("t2_first", {24'd0, d8}, 32'h0);
        for (int i = 1; i < 8; i++) begin
            en = 1'b0;
            step();
            exp = (32'd1 << (i - 1)) - 32'd1;
            check($sformatf("t2_gap%0d", i), {24'd0, d8}, exp);
            en = 1'b1;
            step();
            exp = (32'd1 << i) - 32'd1;
            check($sformatf("t2_fill%0d", i), {24'd0, d8}, exp);
        end
        en = 1'b0; step();
        check("t2_gap8", {24'd0, d8}, 32'h7F);
        en = 1'b1; step();
        check("t2_hold_a", {23'd0, lo8, d8}, 32'hFF);
        en = 1'b0; step();
        check("t2_hold_b", {23'd0, lo8, d8}, 32'hFF);
        en = 1'b1; step();
        check("t2_out", {22'd0, busy8, lo8, d8}, 32'h100);
        en = 1'b0; step();
        check("t2_after", {22'd0, busy8, lo8, d8}, 32'h0);
        $display("test2 zero delay / en gating done");

        // 3: re-trigger while filling is ignored
        en = 1'b1; delay = 7'd3; trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int i = 1; i <= 4; i++) step();
        check("t3_at0F", {24'd0, d8}, 32'h0F);
        trigger = 1'b1; delay = 7'd9;
        step();
        trigger = 1'b0;
        check("t3_cont", {24'd0, d8}, 32'h1F);
        step(); step();
        check("t3_7F", {24'd0, d8}, 32'h7F);
        hold_cnt = 0;
        for (int c = 0; c < 20 && !lo8; c++) begin
            step();
            if (d8 == 8'hFF && busy8) hold_cnt++;
        end
        check("t3_hold_len", hold_cnt, 32'd4);
        check("t3_pulse", {31'd0, lo8}, 32'h1);
        step();
        $display("test3 re-trigger ignored done");

        // 4: abort in HOLD with timer=2
        delay = 7'd3; trigger = 1'b1;
        step();
        trigger = 1'b0;
        for (int i = 1; i <= 8; i++) step();
        check("t4_hold_t3", {24'd0, d8}, 32'hFF);
        step();
        check("t4_hold_t2", {24'd0, d8}, 32'hFF);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_abort", {22'd0, busy8, lo8, d8}, 32'h0);
        for (int c = 0; c < 4; c++) begin
            step();
            check($sformatf("t4_nolo%0d", c), {22'd0, busy8, lo8, d8}, 32'h0);
        end
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("t4_restart", {23'd0, busy8, d8}, 32'h100);
        step();
        check("t4_restart1", {24'd0, d8}, 32'h01);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_abort_fill", {31'd0, busy8}, 32'h0);
        $display("test4 abort in hold done");

        // 5: asynchronous reset in FILL
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        step(); step(); step();
        check("t5_at07", {24'd0, d8}, 32'h07);
        #3 rst = 1'b0;
        #1;
        check("t5_async", {23'd0, busy8, d8}, 32'h0);
        step();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("t5_idle%0d", c), {23'd0, busy8, d8}, 32'h0);
        end
        $display("test5 async reset done");

        // 6: NUM_LIGHTS=1 and 32, DELAY_W=4, delay 15
        do_reset();
        delay = 7'd15; en = 1'b1; trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("t6_first32", d32, 32'h0);
        h1 = 0; h32 = 0; f1c = 1; f32c = 1; p1 = 0; p32 = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (c == 0)  check("t6_n1_full", {31'd0, d1}, 32'h1);
            if (c == 30) check("t6_n32_7F", d32, 32'h7FFFFFFF);
            if (c == 31) check("t6_n32_full", d32, 32'hFFFFFFFF);
            if (busy1 && d1 == 1'b1) h1++;
            else if (busy1) f1c++;
            if (busy32 && d32 == 32'hFFFFFFFF) h32++;
            else if (busy32) f32c++;
            if (lo1) p1++;
            if (lo32) p32++;
        end
        check("t6_n1_fill",   f1c,  32'd1);
        check("t6_n1_hold",   h1,   32'd16);
        check("t6_n1_pulse",  p1,   32'd1);
        check("t6_n32_fill",  f32c, 32'd32);
        check("t6_n32_hold",  h32,  32'd16);
        check("t6_n32_pulse", p32,  32'd1);
        check("t6_end_busy", {30'd0, busy1, busy32}, 32'h0);
        $display("test6 parameter sweep done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
